cascade_counter_chain: RTL and testbench

Multi-stage cascaded counter for the HUB-75 scan path: a parametrised chain of wrap-around stages such as column, row and bit-plane. It generalises the single-stage cascade counter with per-stage runtime limits, up/down counting, synchronous clear and registered wrap pulses. Limit changes are shadowed and applied only at a full-chain wrap or a clear, so a frame is never torn mid-scan. It sits between the frame timing controller and the pixel-fetch / row-select logic.

---
 rtl/cascade_counter_chain.sv | 130 +++++++++++++
 tb/tb_cascade_counter_chain.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cascade_counter_chain.sv
// Cascaded wrap-around counter chain (column/row/bit-plane) with per-stage runtime limits,
// up/down stepping and limit shadowing so a new scan geometry only lands at a frame boundary.

module ccc_stage #(
   parameter int unsigned     BW          = 8,
   parameter logic [BW-1:0]   DEFAULT_MAX = '1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          carry_i,
   input  logic          clear_i,
   input  logic          down_i,
   input  logic          lim_upd_i,
   input  logic [BW-1:0] lim_src_i,
   output logic          carry_o,
   output logic          wrap_o,
   output logic [BW-1:0] count_o
);
   localparam logic [BW-1:0] ONE = BW'(1);

   logic [BW-1:0] count_q, count_d, lim_q, lim_d;
   logic          wrap_q, wrap_d, term;

   always_comb begin
      term    = down_i ? (count_q == '0) : (count_q == lim_q);
      carry_o = carry_i & term;
      lim_d   = lim_upd_i ? lim_src_i : lim_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (carry_i) begin
         if (term) begin
            wrap_d  = 1'b1;
            // down wrap reloads from the limit that is active after this step
            count_d = down_i ? lim_d : '0;
         end else begin
            count_d = down_i ? (count_q - ONE) : (count_q + ONE);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         lim_q   <= DEFAULT_MAX;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         lim_q   <= lim_d;
         wrap_q  <= wrap_d;
      end
   end

   assign wrap_o  = wrap_q;
   assign count_o = count_q;
endmodule

module cascade_counter_chain #(
   parameter int unsigned STAGE_COUNT = 3,
   parameter int unsigned BIT_WIDTH   = 8,
   parameter int unsigned DEFAULT_MAX = 2**BIT_WIDTH - 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           enable_i,
   input  logic                           clear_i,
   input  logic                           down_i,
   input  logic [STAGE_COUNT*BIT_WIDTH-1:0] limit_i,
   input  logic                           limit_load_i,
   output logic [STAGE_COUNT*BIT_WIDTH-1:0] count_o,
   output logic [STAGE_COUNT-1:0]         stage_wrap_o,
   output logic                           chain_wrap_o,
   output logic                           is_zero_o,
   output logic                           limit_pending_o
);
   localparam int unsigned LW = STAGE_COUNT*BIT_WIDTH;

   logic [STAGE_COUNT:0] carry;
   logic [LW-1:0]        pend_q, pend_d, lim_src;
   logic                 pend_vld_q, pend_vld_d, apply, lim_upd;

   always_comb begin
      carry[0]   = enable_i & ~clear_i;
      apply      = clear_i | carry[STAGE_COUNT];
      // a load in the applying cycle wins over any older shadow value
      lim_upd    = apply & (limit_load_i | pend_vld_q);
      lim_src    = limit_load_i ? limit_i : pend_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (apply) begin
         pend_vld_d = 1'b0;
      end else if (limit_load_i) begin
         pend_d     = limit_i;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   for (genvar i = 0; i < STAGE_COUNT; i++) begin : g_stage
      ccc_stage #(
         .BW          (BIT_WIDTH),
         .DEFAULT_MAX (BIT_WIDTH'(DEFAULT_MAX))
      ) u_stage (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .carry_i   (carry[i]),
         .clear_i   (clear_i),
         .down_i    (down_i),
         .lim_upd_i (lim_upd),
         .lim_src_i (lim_src[i*BIT_WIDTH +: BIT_WIDTH]),
         .carry_o   (carry[i+1]),
         .wrap_o    (stage_wrap_o[i]),
         .count_o   (count_o[i*BIT_WIDTH +: BIT_WIDTH])
      );
   end

   assign chain_wrap_o    = stage_wrap_o[STAGE_COUNT-1];
   assign is_zero_o       = (count_o == '0);
   assign limit_pending_o = pend_vld_q;
endmodule

// File: tb/tb_cascade_counter_chain.sv
// Directed bench for cascade_counter_chain with 2 stages of 4 bits (default limit 15).

module tb_cascade_counter_chain;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, clr, dn, ld;
   logic [7:0] lim;
   logic [7:0] cnt;
   logic [1:0] sw;
   logic       cw, iz, lp;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   cascade_counter_chain #(
      .STAGE_COUNT (2),
      .BIT_WIDTH   (4),
      .DEFAULT_MAX (15)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .enable_i        (en),
      .clear_i         (clr),
      .down_i          (dn),
      .limit_i         (lim),
      .limit_load_i    (ld),
      .count_o         (cnt),
      .stage_wrap_o    (sw),
      .chain_wrap_o    (cw),
      .is_zero_o       (iz),
      .limit_pending_o (lp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic c, input logic d, input logic l, input logic [7:0] v);
      en = e; clr = c; dn = d; ld = l; lim = v;
   endtask

   int s0, s1;

   initial begin
      drive(0, 0, 0, 0, 8'h00);
      rst_n = 1'b0;
      #12;
      chk("rst_count", 32'(cnt), 32'h00);
      chk("rst_wrap",  32'(sw),  32'h0);
      chk("rst_chain", 32'(cw),  32'h0);
      chk("rst_zero",  32'(iz),  32'h1);
      chk("rst_pend",  32'(lp),  32'h0);
      rst_n = 1'b1;

      // down from reset: chain wraps into the default limits
      drive(1, 0, 1, 0, 8'h00);
      tick();
      chk("dn1_count", 32'(cnt), 32'hFF);
      chk("dn1_wrap",  32'(sw),  32'h3);
      chk("dn1_chain", 32'(cw),  32'h1);
      tick();
      chk("dn2_count", 32'(cnt), 32'hFE);
      chk("dn2_wrap",  32'(sw),  32'h0);
      chk("dn2_zero",  32'(iz),  32'h0);

      // clear with load: limits {3,2} take effect at once
      drive(0, 1, 0, 1, 8'h32);
      tick();
      chk("clr_count", 32'(cnt), 32'h00);
      chk("clr_pend",  32'(lp),  32'h0);
      chk("clr_zero",  32'(iz),  32'h1);

      drive(1, 0, 0, 0, 8'h00);
      for (int k = 1; k <= 19; k++) begin
         tick();
         s0 = k % 3;
         s1 = (k / 3) % 4;
         chk("up_count", 32'(cnt), 32'((s1 << 4) | s0));
         chk("up_wrap0", 32'(sw[0]), ((k % 3) == 0) ? 32'h1 : 32'h0);
         chk("up_chain", 32'(cw),    ((k % 12) == 0) ? 32'h1 : 32'h0);
      end
      chk("at21", 32'(cnt), 32'h21);

      // shadowed load mid-frame: old limits persist until chain wrap
      drive(1, 0, 0, 1, 8'h11);
      tick();
      chk("shd_count", 32'(cnt), 32'h22);
      chk("shd_pend",  32'(lp),  32'h1);
      drive(1, 0, 0, 0, 8'h00);
      tick(); chk("shd_30", 32'(cnt), 32'h30);
      tick(); chk("shd_31", 32'(cnt), 32'h31);
      tick(); chk("shd_32", 32'(cnt), 32'h32);
      chk("shd_pend2", 32'(lp), 32'h1);
      tick();
      chk("shd_wrap_cnt",   32'(cnt), 32'h00);
      chk("shd_wrap_chain", 32'(cw),  32'h1);
      chk("shd_wrap_pend",  32'(lp),  32'h0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("new_chain", 32'(cw), ((k % 4) == 0) ? 32'h1 : 32'h0);
      end

      // back to {3,2}, then clear+enable at (1,2)
      drive(0, 1, 0, 1, 8'h32);
      tick();
      drive(1, 0, 0, 0, 8'h00);
      repeat (5) tick();
      chk("at12", 32'(cnt), 32'h12);
      drive(1, 1, 0, 0, 8'h00);
      tick();
      chk("ce_count", 32'(cnt), 32'h00);
      chk("ce_wrap",  32'(sw),  32'h0);

      // load coinciding with clear at (2,1)
      drive(1, 0, 0, 0, 8'h00);
      repeat (7) tick();
      chk("at21b", 32'(cnt), 32'h21);
      drive(0, 1, 0, 1, 8'h11);
      tick();
      chk("lc_count", 32'(cnt), 32'h00);
      chk("lc_pend",  32'(lp),  32'h0);
      drive(1, 0, 0, 0, 8'h00);
      tick(); chk("lc_01", 32'(cnt), 32'h01);
      tick();
      chk("lc_10",   32'(cnt), 32'h10);
      chk("lc_wrap", 32'(sw),  32'h1);

      // stage 0 limit 0 is always terminal and passes carry
      drive(0, 1, 0, 1, 8'h20);
      tick();
      drive(1, 0, 0, 0, 8'h00);
      tick(); chk("l0_10", 32'(cnt), 32'h10); chk("l0_w1", 32'(sw), 32'h1);
      tick(); chk("l0_20", 32'(cnt), 32'h20); chk("l0_w2", 32'(sw), 32'h1);
      tick(); chk("l0_00", 32'(cnt), 32'h00); chk("l0_w3", 32'(sw), 32'h3);
      chk("l0_chain", 32'(cw), 32'h1);

      // async reset with a pending limit and a nonzero count
      drive(1, 0, 0, 1, 8'h33);
      tick();
      chk("pr_count", 32'(cnt), 32'h10);
      chk("pr_pend",  32'(lp),  32'h1);
      drive(0, 0, 0, 0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_count", 32'(cnt), 32'h00);
      chk("ar_wrap",  32'(sw),  32'h0);
      chk("ar_chain", 32'(cw),  32'h0);
      chk("ar_zero",  32'(iz),  32'h1);
      chk("ar_pend",  32'(lp),  32'h0);
      #3;
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 8'h00);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("def_count", 32'(cnt), 32'(((k / 16) << 4) | (k % 16)));
      end
      chk("def_wrap", 32'(sw), 32'h1);
      chk("def_pend", 32'(lp), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
